multimode_counter: RTL

- Parametrised free-running/event counter; successor to the fixed 20-bit up-counter.
- Adds:
  - configurable width
  - up/down direction
  - programmable limit, with wrap or saturate behaviour
  - clock-enable prescaler
  - synchronous clear and parallel load
  - compare match, terminal-count pulse and sticky overflow flag
- Used as a timebase and event counter by datapath and test logic.

---
 rtl/multimode_counter.sv | 119 +++++++++++
 1 files changed

// File: rtl/multimode_counter.sv
`default_nettype none
// ============================================================================
// Module      : multimode_counter
// Description : Parametrised up/down event counter with programmable limit,
//               wrap/saturate boundary behaviour, clock-enable prescaler,
//               synchronous clear/load, compare match, terminal-count pulse
//               and sticky overflow flag.
// Revision    : 1.0 - initial release (successor to fixed 20-bit up-counter)
// ============================================================================
module multimode_counter #(
    parameter int WIDTH      = 20,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  dir,
    input  logic                  sat_mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      cmp_val,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      out,
    output logic                  tc,
    output logic                  cmp_match,
    output logic                  ovf_sticky
);

    localparam logic [WIDTH-1:0]      c_zero   = '0;
    localparam logic [WIDTH-1:0]      c_one    = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] c_p_one  = PRESCALE_W'(1);

    logic [WIDTH-1:0]      r_out;
    logic                  r_tc;
    logic                  r_ovf;
    logic [PRESCALE_W-1:0] r_presc;

    logic                  w_presc_hit;
    logic                  w_step;
    logic                  w_boundary;
    logic [WIDTH-1:0]      w_next;

    // A ">=" compare so that lowering prescale below the running count
    // still produces a step on the next enabled cycle.
    assign w_presc_hit = en && (r_presc >= prescale);

    // clr and load take priority over stepping, so a step only happens
    // when neither is asserted.
    assign w_step = w_presc_hit && !clr && !load;

    // Next count value and boundary detection for the sampled direction/mode.
    always_comb begin
        w_next     = r_out;
        w_boundary = 1'b0;
        if (dir) begin
            if (r_out < limit) begin
                w_next = r_out + c_one;
            end else begin
                w_boundary = 1'b1;
                w_next     = sat_mode ? limit : c_zero;
            end
        end else begin
            if (r_out != c_zero) begin
                w_next = r_out - c_one;
            end else begin
                w_boundary = 1'b1;
                w_next     = sat_mode ? c_zero : limit;
            end
        end
    end

    // Counter, prescaler and terminal-count pulse with clr > load > step priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= c_zero;
            r_presc <= '0;
            r_tc    <= 1'b0;
        end else if (clr) begin
            r_out   <= c_zero;
            r_presc <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_out   <= load_val;
            r_presc <= '0;
            r_tc    <= 1'b0;
        end else begin
            if (en) begin
                r_presc <= w_presc_hit ? '0 : (r_presc + c_p_one);
            end
            if (w_step) begin
                r_out <= w_next;
                r_tc  <= w_boundary;
            end else begin
                r_tc  <= 1'b0;
            end
        end
    end

    // Sticky overflow: a boundary step wins over a simultaneous clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_step && w_boundary) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign out        = r_out;
    assign tc         = r_tc;
    assign ovf_sticky = r_ovf;
    assign cmp_match  = (r_out == cmp_val);

endmodule
`default_nettype wire
